butterfly_dif: RTL

Radix-2 decimation-in-frequency butterfly for the shared-resource FFT datapath: out_x0 = x0 + x1, out_x1 = (x0 − x1)·W. It is the DIF counterpart of the team's DIT butterfly and serves inverse-direction and DIF-ordered pipelines. It uses the same time-shared scheme: two multipliers serve four real products over two cycles, giving one butterfly per two clocks behind a valid/ready input handshake.

---
 rtl/butterfly_dif.sv | 139 +++++++++++++
 1 files changed

// File: rtl/butterfly_dif.sv
`default_nettype none
// ----------------------------------------------------------------------------
// butterfly_dif : radix-2 DIF butterfly, out_x0 = x0 + x1, out_x1 = (x0-x1)*W
// Two time-shared multipliers, one butterfly every two clocks.
// Revision: 1.0
// ----------------------------------------------------------------------------
module butterfly_dif #(
  parameter int DATA_WIDTH   = 32,
  parameter int FACTOR_WIDTH = 16,
  parameter int FRAC_BITS    = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_x0,
  input  logic [2*DATA_WIDTH-1:0]   in_x1,
  input  logic [2*FACTOR_WIDTH-1:0] w,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   out_x0,
  output logic [2*DATA_WIDTH-1:0]   out_x1
);

  localparam int PROD_WIDTH = DATA_WIDTH + FACTOR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL0 = 2'd1,
    MUL1 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]   s_r_q, s_r_d, s_i_q, s_i_d;
  logic signed [DATA_WIDTH-1:0]   d_r_q, d_r_d, d_i_q, d_i_d;
  logic signed [DATA_WIDTH-1:0]   re_q, re_d;
  logic signed [FACTOR_WIDTH-1:0] w_r_q, w_r_d, w_i_q, w_i_d;
  logic                           out_valid_q, out_valid_d;
  logic [2*DATA_WIDTH-1:0]        out_x0_q, out_x0_d, out_x1_q, out_x1_d;

  logic                           accept;
  logic signed [FACTOR_WIDTH-1:0] mul1_b, mul2_b;
  logic signed [PROD_WIDTH-1:0]   mul1_a_ext, mul1_b_ext, mul2_a_ext, mul2_b_ext;
  logic signed [PROD_WIDTH-1:0]   prod1, prod2;
  logic signed [DATA_WIDTH-1:0]   trunc1, trunc2, im;

  assign in_ready  = !rst && (state_q != MUL0);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_x0    = out_x0_q;
  assign out_x1    = out_x1_q;

  // Only the twiddle side is muxed: MUL0 pairs (d_r,w_r)/(d_i,w_i), MUL1 swaps the twiddles.
  always_comb begin
    mul1_b     = (state_q == MUL1) ? w_i_q : w_r_q;
    mul2_b     = (state_q == MUL1) ? w_r_q : w_i_q;
    mul1_a_ext = {{FACTOR_WIDTH{d_r_q[DATA_WIDTH-1]}}, d_r_q};
    mul2_a_ext = {{FACTOR_WIDTH{d_i_q[DATA_WIDTH-1]}}, d_i_q};
    mul1_b_ext = {{DATA_WIDTH{mul1_b[FACTOR_WIDTH-1]}}, mul1_b};
    mul2_b_ext = {{DATA_WIDTH{mul2_b[FACTOR_WIDTH-1]}}, mul2_b};
    prod1      = mul1_a_ext * mul1_b_ext;
    prod2      = mul2_a_ext * mul2_b_ext;
    // Arithmetic shift floors; the cast keeps p[DATA_WIDTH+FRAC_BITS-1:FRAC_BITS].
    trunc1     = DATA_WIDTH'(prod1 >>> FRAC_BITS);
    trunc2     = DATA_WIDTH'(prod2 >>> FRAC_BITS);
    im         = trunc1 + trunc2;
  end

  always_comb begin
    state_d     = state_q;
    s_r_d       = s_r_q;
    s_i_d       = s_i_q;
    d_r_d       = d_r_q;
    d_i_d       = d_i_q;
    w_r_d       = w_r_q;
    w_i_d       = w_i_q;
    re_d        = re_q;
    out_valid_d = 1'b0;
    out_x0_d    = out_x0_q;
    out_x1_d    = out_x1_q;

    case (state_q)
      IDLE:    state_d = accept ? MUL0 : IDLE;
      MUL0:    state_d = MUL1;
      MUL1:    state_d = accept ? MUL0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      s_r_d = in_x0[2*DATA_WIDTH-1:DATA_WIDTH] + in_x1[2*DATA_WIDTH-1:DATA_WIDTH];
      s_i_d = in_x0[DATA_WIDTH-1:0] + in_x1[DATA_WIDTH-1:0];
      d_r_d = in_x0[2*DATA_WIDTH-1:DATA_WIDTH] - in_x1[2*DATA_WIDTH-1:DATA_WIDTH];
      d_i_d = in_x0[DATA_WIDTH-1:0] - in_x1[DATA_WIDTH-1:0];
      w_r_d = w[2*FACTOR_WIDTH-1:FACTOR_WIDTH];
      w_i_d = w[FACTOR_WIDTH-1:0];
    end

    if (state_q == MUL0) begin
      re_d = trunc1 - trunc2;
    end

    // Output regs read the current s/re/im even when a new accept overwrites them.
    if (state_q == MUL1) begin
      out_valid_d = 1'b1;
      out_x0_d    = {s_r_q, s_i_q};
      out_x1_d    = {re_q, im};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_r_q       <= '0;
      s_i_q       <= '0;
      d_r_q       <= '0;
      d_i_q       <= '0;
      w_r_q       <= '0;
      w_i_q       <= '0;
      re_q        <= '0;
      out_valid_q <= 1'b0;
      out_x0_q    <= '0;
      out_x1_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_r_q       <= s_r_d;
      s_i_q       <= s_i_d;
      d_r_q       <= d_r_d;
      d_i_q       <= d_i_d;
      w_r_q       <= w_r_d;
      w_i_q       <= w_i_d;
      re_q        <= re_d;
      out_valid_q <= out_valid_d;
      out_x0_q    <= out_x0_d;
      out_x1_q    <= out_x1_d;
    end
  end

endmodule
`default_nettype wire
